// File: rtl/ld_cell_sampler.sv
// Load-cell sampler: each period it converts the left then the right load cell
// through the A2D handshake and low-pass filters both readings.
//
// state  | meaning
// IDLE   | waiting for the period counter to roll over
// REQ_L  | issue strt_cnv on the left channel, arm timeout
// WAIT_L | wait for cnv_cmplt on the left channel or timeout
// REQ_R  | issue strt_cnv on the right channel, arm timeout
// WAIT_R | wait for cnv_cmplt on the right channel or timeout
// UPD    | load or filter both outputs, clear a2d_err, pulse ld_vld
module ld_cell_sampler #(
  parameter logic [2:0] CHNL_LFT  = 3'd0,
  parameter logic [2:0] CHNL_RGHT = 3'd4,
  parameter bit         fast_sim  = 1'b0,
  parameter int         TMO_CYC   = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic        ld_vld,
  output logic        a2d_err
);

  localparam int PW = fast_sim ? 10 : 20;
  localparam int TW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [TW-1:0] TMO_LD = TW'(TMO_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_L  = 3'd1,
    WAIT_L = 3'd2,
    REQ_R  = 3'd3,
    WAIT_R = 3'd4,
    UPD    = 3'd5
  } state_t;

  state_t        state;
  logic [PW-1:0] prd_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [11:0]   sample_l;
  logic [11:0]   sample_r;
  logic          primed;
  logic          rnd_trig;

  // 1/4-weight exponential average with rounding; 14 bits cannot overflow
  function automatic logic [11:0] lp_filt(input logic [11:0] prev, input logic [11:0] smpl);
    logic [13:0] acc;
    acc = {2'b00, prev} + {2'b00, prev} + {2'b00, prev} + {2'b00, smpl} + 14'd2;
    return acc[13:2];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prd_cnt <= '0;
    else     prd_cnt <= prd_cnt + 1'b1;
  end

  assign rnd_trig = &prd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      strt_cnv <= 1'b0;
      chnnl    <= CHNL_LFT;
      tmo_cnt  <= '0;
      sample_l <= '0;
      sample_r <= '0;
      primed   <= 1'b0;
      lft_ld   <= '0;
      rght_ld  <= '0;
      ld_vld   <= 1'b0;
      a2d_err  <= 1'b0;
    end else begin
      strt_cnv <= 1'b0;
      ld_vld   <= 1'b0;
      case (state)
        IDLE: if (rnd_trig) state <= REQ_L;
        REQ_L: begin
          strt_cnv <= 1'b1;
          chnnl    <= CHNL_LFT;
          tmo_cnt  <= TMO_LD;
          state    <= WAIT_L;
        end
        // completion wins over a timeout landing in the same cycle
        WAIT_L: begin
          if (cnv_cmplt) begin
            sample_l <= res;
            state    <= REQ_R;
          end else if (tmo_cnt == '0) begin
            a2d_err <= 1'b1;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        REQ_R: begin
          strt_cnv <= 1'b1;
          chnnl    <= CHNL_RGHT;
          tmo_cnt  <= TMO_LD;
          state    <= WAIT_R;
        end
        WAIT_R: begin
          if (cnv_cmplt) begin
            sample_r <= res;
            state    <= UPD;
          end else if (tmo_cnt == '0) begin
            a2d_err <= 1'b1;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        UPD: begin
          if (!primed) begin
            lft_ld  <= sample_l;
            rght_ld <= sample_r;
            primed  <= 1'b1;
          end else begin
            lft_ld  <= lp_filt(lft_ld, sample_l);
            rght_ld <= lp_filt(rght_ld, sample_r);
          end
          a2d_err <= 1'b0;
          ld_vld  <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ld_cell_sampler.sv
// Bench for ld_cell_sampler: A2D responder, deadline-based reference model
// checked every cycle, and directed rounds with hand-computed results.
module tb_ld_cell_sampler;

  logic        clk;
  logic        rst;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        ld_vld;
  logic        a2d_err;

  int n_chk = 0;
  int n_err = 0;

  // responder configuration, written only by the main sequence
  logic [11:0] resp_l;
  logic [11:0] resp_r;
  int          dly_l;
  int          dly_r;
  bit          withhold_r;
  int          spur_req;

  ld_cell_sampler #(
    .CHNL_LFT (3'd0),
    .CHNL_RGHT(3'd4),
    .fast_sim (1'b1),
    .TMO_CYC  (256)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .strt_cnv (strt_cnv),
    .chnnl    (chnnl),
    .cnv_cmplt(cnv_cmplt),
    .res      (res),
    .lft_ld   (lft_ld),
    .rght_ld  (rght_ld),
    .ld_vld   (ld_vld),
    .a2d_err  (a2d_err)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A2D responder: answers dly cycles after it sees strt_cnv
  initial begin : a2d
    int          cnt_dn;
    int          spur_done;
    logic [11:0] pend;
    cnt_dn = 0;
    spur_done = 0;
    pend = '0;
    cnv_cmplt = 1'b0;
    res = '0;
    forever begin
      @(posedge clk);
      #1;
      cnv_cmplt = 1'b0;
      if (rst) begin
        cnt_dn = 0;
      end else begin
        if (cnt_dn > 0) begin
          cnt_dn--;
          if (cnt_dn == 0) begin
            cnv_cmplt = 1'b1;
            res = pend;
          end
        end else if (spur_req != spur_done) begin
          spur_done = spur_req;
          cnv_cmplt = 1'b1;
          res = 12'hABC;
        end
        if (strt_cnv) begin
          if (chnnl == 3'd4) begin
            if (!withhold_r) begin
              cnt_dn = dly_r;
              pend = resp_r;
            end
          end else begin
            cnt_dn = dly_l;
            pend = resp_l;
          end
        end
      end
    end
  end

  // Reference model: a round is a chain of deadlines measured in cycles since
  // reset release; outputs are derived from those deadlines and the samples.
  int          m_n;
  int          m_strt_time;
  int          m_upd_time;
  int          m_err_time;
  int          m_idle_from;
  bit          m_active;
  bit          m_right;
  bit          m_primed;
  logic [11:0] m_s_l;
  logic [11:0] m_s_r;
  logic [11:0] m_e_lft;
  logic [11:0] m_e_rght;
  logic [2:0]  m_e_ch;
  logic        m_e_err;
  logic        m_e_vld;
  logic        m_e_strt;

  initial begin : model
    forever begin
      @(negedge clk);
      if (rst) begin
        m_n = 0; m_strt_time = -1; m_upd_time = -1; m_err_time = -1; m_idle_from = 0;
        m_active = 0; m_right = 0; m_primed = 0;
        m_s_l = '0; m_s_r = '0; m_e_lft = '0; m_e_rght = '0;
        m_e_ch = 3'd0; m_e_err = 1'b0; m_e_vld = 1'b0; m_e_strt = 1'b0;
      end else begin
        m_e_vld  = (m_n == m_upd_time);
        m_e_strt = (m_n == m_strt_time);
        if (m_n == m_upd_time) begin
          if (!m_primed) begin
            m_e_lft = m_s_l;
            m_e_rght = m_s_r;
            m_primed = 1;
          end else begin
            m_e_lft  = 12'((3 * int'(m_e_lft) + int'(m_s_l) + 2) / 4);
            m_e_rght = 12'((3 * int'(m_e_rght) + int'(m_s_r) + 2) / 4);
          end
          m_e_err = 1'b0;
        end
        if (m_n == m_err_time) m_e_err = 1'b1;
        if (m_n == m_strt_time) m_e_ch = m_right ? 3'd4 : 3'd0;
      end
      check("strt_cnv", int'(strt_cnv), int'(m_e_strt));
      check("chnnl", int'(chnnl), int'(m_e_ch));
      check("lft_ld", int'(lft_ld), int'(m_e_lft));
      check("rght_ld", int'(rght_ld), int'(m_e_rght));
      check("ld_vld", int'(ld_vld), int'(m_e_vld));
      check("a2d_err", int'(a2d_err), int'(m_e_err));
      if (!rst) begin
        if (m_active && m_strt_time >= 0 && m_n >= m_strt_time) begin
          if (cnv_cmplt) begin
            if (!m_right) begin
              m_s_l = res;
              m_right = 1;
              m_strt_time = m_n + 2;
            end else begin
              m_s_r = res;
              m_upd_time = m_n + 2;
              m_idle_from = m_n + 2;
              m_active = 0;
              m_strt_time = -1;
            end
          end else if (m_n == m_strt_time + 255) begin
            m_err_time = m_n + 1;
            m_idle_from = m_n + 1;
            m_active = 0;
            m_strt_time = -1;
          end
        end else if (!m_active && m_n >= m_idle_from && (m_n % 1024) == 1023) begin
          m_active = 1;
          m_right = 0;
          m_strt_time = m_n + 2;
        end
        m_n++;
      end
    end
  end

  task automatic wait_vld(input string name, output int cyc);
    bit seen;
    seen = 0;
    cyc = 0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      if (ld_vld) seen = 1;
      else cyc++;
    end
    check(name, int'(seen), 1);
  endtask

  task automatic wait_strt_r(input string name);
    bit seen;
    int cyc;
    seen = 0;
    cyc = 0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      if (strt_cnv && chnnl == 3'd4) seen = 1;
      else cyc++;
    end
    check(name, int'(seen), 1);
  endtask

  initial begin : main
    int cyc;
    int k;
    int nv;
    rst = 1'b1;
    resp_l = 12'h300; resp_r = 12'h100;
    dly_l = 20; dly_r = 20;
    withhold_r = 0; spur_req = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // first round loads raw samples
    wait_vld("r1_vld", cyc);
    check("r1_latency", cyc, 1069);
    check("r1_lft", int'(lft_ld), 'h300);
    check("r1_rght", int'(rght_ld), 'h100);
    resp_l = 12'h400;
    @(negedge clk);
    check("r1_vld_width", int'(ld_vld), 0);

    wait_vld("r2_vld", cyc);
    check("r2_lft", int'(lft_ld), 'h340);
    check("r2_rght", int'(rght_ld), 'h100);

    // full-scale input held: prime to FFF then stay there
    @(posedge clk);
    #1 rst = 1'b1;
    resp_l = 12'hFFF; resp_r = 12'hFFF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wait_vld("fff_vld", cyc);
      check("fff_lft", int'(lft_ld), 'hFFF);
      check("fff_rght", int'(rght_ld), 'hFFF);
    end

    // right conversion never answers
    withhold_r = 1;
    wait_strt_r("tmo_strt");
    k = 0;
    nv = 0;
    while (!a2d_err && k < 400) begin
      @(negedge clk);
      k++;
      if (ld_vld) nv++;
    end
    check("tmo_delay", k, 256);
    check("tmo_no_vld", nv, 0);
    check("tmo_lft", int'(lft_ld), 'hFFF);
    check("tmo_rght", int'(rght_ld), 'hFFF);
    withhold_r = 0;
    resp_l = 12'h7FF; resp_r = 12'h7FF;

    wait_vld("rec_vld", cyc);
    check("rec_lft", int'(lft_ld), 'hDFF);
    check("rec_rght", int'(rght_ld), 'hDFF);
    check("rec_err_clr", int'(a2d_err), 0);

    // stray completion while idle
    repeat (3) @(negedge clk);
    spur_req++;
    repeat (6) @(negedge clk);
    check("spur_lft", int'(lft_ld), 'hDFF);
    check("spur_rght", int'(rght_ld), 'hDFF);
    check("spur_err", int'(a2d_err), 0);

    // completion on the last cycle before timeout
    dly_r = 255;
    wait_vld("coin_vld", cyc);
    check("coin_lft", int'(lft_ld), 'hC7F);
    check("coin_rght", int'(rght_ld), 'hC7F);
    check("coin_err", int'(a2d_err), 0);
    dly_r = 20;

    // reset mid-round, then raw reload
    wait_strt_r("rst_strt");
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_lft", int'(lft_ld), 0);
    check("rst_rght", int'(rght_ld), 0);
    check("rst_chnnl", int'(chnnl), 0);
    check("rst_err", int'(a2d_err), 0);
    resp_l = 12'h123; resp_r = 12'h456;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_vld("raw_vld", cyc);
    check("raw_latency", cyc, 1069);
    check("raw_lft", int'(lft_ld), 'h123);
    check("raw_rght", int'(rght_ld), 'h456);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ld_cell_sampler.md
Name: ld_cell_sampler

Overview:
- Upstream feeder for the steering-enable stage.
- Periodically sequences two A2D conversions, left load cell then right load cell, over a start/complete handshake.
- Low-pass filters each reading with a 1/4-weight exponential average.
- Presents stable 12-bit lft_ld / rght_ld plus a one-cycle ld_vld pulse per completed round.

Parameters:
- CHNL_LFT, 3'd0, A2D channel number of the left load cell.
- CHNL_RGHT, 3'd4, A2D channel number of the right load cell.
- fast_sim, 0, when 1 the round period counter uses 10 bits instead of 20.
- TMO_CYC, 256, clocks allowed between strt_cnv and cnv_cmplt before abort.

Ports:
- clk  input  1  50MHz system clock
- rst  input  1  asynchronous active-high reset
- strt_cnv  output  1  one-cycle pulse requesting a conversion on chnnl
- chnnl  output  3  channel select; held stable from strt_cnv until cnv_cmplt or timeout
- cnv_cmplt  input  1  one-cycle pulse from A2D; res valid in that cycle
- res  input  12  unsigned conversion result
- lft_ld  output  12  filtered left load
- rght_ld  output  12  filtered right load
- ld_vld  output  1  one-cycle pulse after both outputs are updated in a round
- a2d_err  output  1  sticky timeout flag; cleared by next fully successful round

Behaviour:
- Reset values (async on rst high):
  - strt_cnv=0, chnnl=CHNL_LFT, lft_ld=0, rght_ld=0, ld_vld=0, a2d_err=0.
  - Period counter=0, state=IDLE, primed=0.
- Period counter is free-running, 20 bits (10 if fast_sim). Round trigger fires in the cycle the counter equals all-ones.
- States: IDLE, REQ_L, WAIT_L, REQ_R, WAIT_R, UPD.
- IDLE:
  - On trigger, go to REQ_L.
  - A trigger seen while not in IDLE is ignored; no queuing.
- REQ_L:
  - strt_cnv=1 for exactly one cycle, chnnl=CHNL_LFT.
  - Clear timeout counter, go to WAIT_L.
- WAIT_L:
  - On cnv_cmplt, capture res into sample_l, go to REQ_R.
  - If the timeout counter reaches TMO_CYC-1 without cnv_cmplt, set a2d_err, go to IDLE. No outputs update and no ld_vld.
- REQ_R / WAIT_R: same as REQ_L / WAIT_L with CHNL_RGHT and sample_r. Timeout also aborts to IDLE; the left sample is discarded.
- UPD (one cycle):
  - If primed=0: lft_ld<=sample_l, rght_ld<=sample_r, primed<=1.
  - Else: lft_ld<=(3*lft_ld + sample_l + 2)>>2, computed in 14 bits then truncated to 12. Same formula for rght_ld.
  - The result never exceeds 12'hFFF, since inputs are ≤ FFF.
  - a2d_err<=0, then return to IDLE.
  - ld_vld is registered: high the cycle after UPD, when new outputs are already visible.
- cnv_cmplt outside WAIT_L/WAIT_R is ignored.
- cnv_cmplt in the same cycle the timeout would fire counts as success.
- lft_ld / rght_ld change only in UPD. They are stable otherwise, including across aborted rounds.
- rst mid-round: immediate return to reset values. Filter re-primes on the next successful round.
- Latency, trigger to ld_vld: 1 (REQ_L) + conversion-L + 1 (REQ_R) + conversion-R + 1 (UPD) + 1.

Test Plan:
- Reset, fast_sim=1, A2D model answers 20 clocks after strt_cnv with L=12'h300, R=12'h100 -> strt_cnv pulses on chnnl 0 then 4; first ld_vld gives lft_ld=300, rght_ld=100 (primed load); ld_vld width exactly 1.
- Second round, L=12'h400, R=12'h100 -> lft_ld=(3*300+400+2)>>2=12'h340, rght_ld=12'h100.
- Continuous L=R=12'hFFF for 8 rounds from primed 0xFFF -> outputs stay 12'hFFF, no overflow.
- Model withholds cnv_cmplt on the right channel -> a2d_err=1 exactly 256 clocks after the right strt_cnv; outputs unchanged; no ld_vld. The next good round clears a2d_err in the same cycle outputs update.
- Spurious cnv_cmplt with res=12'hABC while IDLE -> no output change. cnv_cmplt coincident with the final timeout cycle -> accepted, no error.
- Assert rst during WAIT_R -> all outputs 0 immediately. After release, the next round loads raw samples (unfiltered).
